// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Operand sequencer for an N x N systolic multiply array (N = MAX_DIM).
//   Reads one packed column of A and one packed row of B per cycle. It zero-pads
//   unused rows/cols for runtime dims M x K x N and skews lane i by i cycles.
//   It runs clear/feed/flush and then pulses done.
//
// Ports
//   clk_i, rst_i        clock (rising edge), asynchronous active-high reset
//   start_i             start request, honoured only in IDLE
//   accumulate_i        1: skip array clear (C += A*B)
//   m/k/n_dim_i         runtime dims, each 1..MAX_DIM
//   busy_o, done_o      op in progress / 1-cycle completion pulse
//   err_o               1-cycle pulse, start rejected because of bad dims
//   clear_o             1-cycle pulse, zero PE accumulators
//   rd_en_o, rd_addr_o  operand read strobe and k index
//   rd_data_a/b_i       A column k / B row k, valid 1 cycle after rd_en_o
//   left_o, up_o        skewed row/column lane inputs to the array
//   lane0_vld_o         slice 0 of left_o/up_o carries a real operand
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | waiting for start_i, dims checked on start
// CLEAR  | one cycle, PE accumulators zeroed
// FEED   | one operand read per cycle, k = 0..K-1
// FLUSH  | FLUSH_LEN cycles for skewed data to drain
// DONE   | one cycle, then back to IDLE
//
// All outputs are registered from the state, so each one appears one cycle
// after the state that produces it.
module systolic_feeder #(
   parameter  int DATA_WIDTH = 32,
   parameter  int MAX_DIM    = 4,
   parameter  int PE_LAT     = 1,
   localparam int DIM_W      = $clog2(MAX_DIM + 1),
   localparam int KA_W       = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic                          accumulate_i,
   input  logic [DIM_W-1:0]              m_dim_i,
   input  logic [DIM_W-1:0]              k_dim_i,
   input  logic [DIM_W-1:0]              n_dim_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic                          clear_o,
   output logic                          rd_en_o,
   output logic [KA_W-1:0]               rd_addr_o,
   input  logic [MAX_DIM*DATA_WIDTH-1:0] rd_data_a_i,
   input  logic [MAX_DIM*DATA_WIDTH-1:0] rd_data_b_i,
   output logic [MAX_DIM*DATA_WIDTH-1:0] left_o,
   output logic [MAX_DIM*DATA_WIDTH-1:0] up_o,
   output logic                          lane0_vld_o
);

   localparam int FLUSH_LEN = 1 + 2 * (MAX_DIM - 1) + PE_LAT;
   localparam int FL_W      = $clog2(FLUSH_LEN + 1);
   localparam int W         = MAX_DIM * DATA_WIDTH;

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [DIM_W-1:0]  k_q, k_d;
   logic [FL_W-1:0]   flush_q, flush_d;
   logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, kd_q, kd_d;
   logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic              clear_q, clear_d, rd_en_q, rd_en_d;
   logic [KA_W-1:0]   rd_addr_q, rd_addr_d;
   logic              vld_in_q, lane0_vld_q;
   logic [W-1:0]      stage0_a_d, stage0_b_d;
   logic              dims_ok;

   always_comb begin
      dims_ok = (m_dim_i != '0) && (m_dim_i <= DIM_W'(MAX_DIM)) &&
                (k_dim_i != '0) && (k_dim_i <= DIM_W'(MAX_DIM)) &&
                (n_dim_i != '0) && (n_dim_i <= DIM_W'(MAX_DIM));
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      flush_d = flush_q;
      m_d     = m_q;
      n_d     = n_q;
      kd_d    = kd_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // done_q high means this is the cycle the DONE pulse is visible;
            // a start seen then is dropped.
            if (start_i && !done_q) begin
               if (!dims_ok) begin
                  err_d = 1'b1;
               end else begin
                  m_d     = m_dim_i;
                  n_d     = n_dim_i;
                  kd_d    = k_dim_i;
                  k_d     = '0;
                  state_d = accumulate_i ? S_FEED : S_CLEAR;
               end
            end
         end
         S_CLEAR: state_d = S_FEED;
         S_FEED: begin
            if (k_q + DIM_W'(1) == kd_q) begin
               k_d     = '0;
               flush_d = FL_W'(FLUSH_LEN - 1);
               state_d = S_FLUSH;
            end else begin
               k_d = k_q + DIM_W'(1);
            end
         end
         S_FLUSH: begin
            if (flush_q == '0) state_d = S_DONE;
            else               flush_d = flush_q - FL_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      busy_d    = (state_q != S_IDLE);
      clear_d   = (state_q == S_CLEAR);
      rd_en_d   = (state_q == S_FEED);
      rd_addr_d = (state_q == S_FEED) ? k_q[KA_W-1:0] : '0;
      done_d    = (state_q == S_DONE);
   end

   // vld_in_q marks the cycle rd_data_* holds a requested column/row. Unused
   // lanes and idle cycles put zeros into the skew chains.
   always_comb begin
      stage0_a_d = '0;
      stage0_b_d = '0;
      for (int i = 0; i < MAX_DIM; i++) begin
         if (vld_in_q && (i < int'(m_q)))
            stage0_a_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_a_i[i*DATA_WIDTH +: DATA_WIDTH];
         if (vld_in_q && (i < int'(n_q)))
            stage0_b_d[i*DATA_WIDTH +: DATA_WIDTH] = rd_data_b_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         flush_q     <= '0;
         m_q         <= '0;
         n_q         <= '0;
         kd_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         clear_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         vld_in_q    <= 1'b0;
         lane0_vld_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         flush_q     <= flush_d;
         m_q         <= m_d;
         n_q         <= n_d;
         kd_q        <= kd_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         clear_q     <= clear_d;
         rd_en_q     <= rd_en_d;
         rd_addr_q   <= rd_addr_d;
         vld_in_q    <= rd_en_q;
         // Aligned with the stage-0 data register, not with rd_data_*.
         lane0_vld_q <= vld_in_q;
      end
   end

   // Lane i is the stage-0 register followed by i more registers.
   for (genvar i = 0; i < MAX_DIM; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] skew_a_q [0:i];
      logic [DATA_WIDTH-1:0] skew_b_q [0:i];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            for (int d = 0; d <= i; d++) begin
               skew_a_q[d] <= '0;
               skew_b_q[d] <= '0;
            end
         end else begin
            skew_a_q[0] <= stage0_a_d[i*DATA_WIDTH +: DATA_WIDTH];
            skew_b_q[0] <= stage0_b_d[i*DATA_WIDTH +: DATA_WIDTH];
            for (int d = 1; d <= i; d++) begin
               skew_a_q[d] <= skew_a_q[d-1];
               skew_b_q[d] <= skew_b_q[d-1];
            end
         end
      end

      assign left_o[i*DATA_WIDTH +: DATA_WIDTH] = skew_a_q[i];
      assign up_o[i*DATA_WIDTH +: DATA_WIDTH]   = skew_b_q[i];
   end

   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign clear_o     = clear_q;
   assign rd_en_o     = rd_en_q;
   assign rd_addr_o   = rd_addr_q;
   assign lane0_vld_o = lane0_vld_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder. It drives directed operations. For each start
// it builds an expected per-cycle timeline of the control outputs. It also
// pushes the expected lane operands into per-lane queues, and a negedge
// monitor compares every cycle against them.
module tb_systolic_feeder;

   localparam int DW    = 32;
   localparam int MD    = 4;
   localparam int PL    = 1;
   localparam int DIM_W = $clog2(MD + 1);
   localparam int KA_W  = 2;
   localparam int F     = 1 + 2 * (MD - 1) + PL;
   localparam int W     = MD * DW;
   localparam int T     = 1024;
   localparam logic [DW-1:0] GARB = 32'hBAD0_0BAD;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b1;
   logic              start_i = 1'b0;
   logic              accumulate_i = 1'b0;
   logic [DIM_W-1:0]  m_dim_i = '0, k_dim_i = '0, n_dim_i = '0;
   logic              busy_o, done_o, err_o, clear_o, rd_en_o, lane0_vld_o;
   logic [KA_W-1:0]   rd_addr_o;
   logic [W-1:0]      rd_data_a_i = '0, rd_data_b_i = '0;
   logic [W-1:0]      left_o, up_o;

   systolic_feeder #(.DATA_WIDTH(DW), .MAX_DIM(MD), .PE_LAT(PL)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .accumulate_i(accumulate_i),
      .m_dim_i(m_dim_i), .k_dim_i(k_dim_i), .n_dim_i(n_dim_i),
      .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .clear_o(clear_o),
      .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
      .rd_data_a_i(rd_data_a_i), .rd_data_b_i(rd_data_b_i),
      .left_o(left_o), .up_o(up_o), .lane0_vld_o(lane0_vld_o)
   );

   always #5 clk_i = ~clk_i;

   logic [DW-1:0] mat_a [MD][MD];
   logic [DW-1:0] mat_b [MD][MD];
   bit            exp_busy [T], exp_done [T], exp_err [T], exp_clear [T], exp_rd [T], exp_vld [T];
   int            exp_addr [T];
   logic [DW-1:0] ql [MD][$];
   logic [DW-1:0] qu [MD][$];
   int            cyc = 0, checks = 0, errors = 0, last_done = 0;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Operand memory: registered read, garbage when not enabled.
   always @(posedge clk_i) begin
      for (int i = 0; i < MD; i++) begin
         rd_data_a_i[i*DW +: DW] <= rd_en_o ? mat_a[i][rd_addr_o] : GARB;
         rd_data_b_i[i*DW +: DW] <= rd_en_o ? mat_b[rd_addr_o][i] : GARB;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   always @(negedge clk_i) begin : mon
      logic [DW-1:0] el, eu;
      chk("busy", busy_o, exp_busy[cyc]);
      chk("done", done_o, exp_done[cyc]);
      chk("err", err_o, exp_err[cyc]);
      chk("clear", clear_o, exp_clear[cyc]);
      chk("rd_en", rd_en_o, exp_rd[cyc]);
      chk("rd_addr", rd_addr_o, exp_addr[cyc]);
      chk("lane0_vld", lane0_vld_o, exp_vld[cyc]);
      for (int i = 0; i < MD; i++) begin
         el = '0;
         eu = '0;
         if (cyc - i >= 0 && exp_vld[cyc - i]) begin
            chk("sb_nonempty", (ql[i].size() > 0) && (qu[i].size() > 0), 1);
            if (ql[i].size() > 0) el = ql[i].pop_front();
            if (qu[i].size() > 0) eu = qu[i].pop_front();
         end
         chk($sformatf("left%0d", i), left_o[i*DW +: DW], el);
         chk($sformatf("up%0d", i), up_o[i*DW +: DW], eu);
      end
   end

   // Expected behaviour of one accepted op whose start is sampled at edge e.
   task automatic sched(input int e, input int m, input int k, input int n, input bit acc);
      int c0, r, d;
      c0 = acc ? 0 : 1;
      if (!acc) exp_clear[e+1] = 1;
      for (int kk = 0; kk < k; kk++) begin
         r = e + 1 + c0 + kk;
         exp_rd[r]    = 1;
         exp_addr[r]  = kk;
         exp_vld[r+2] = 1;
         for (int i = 0; i < MD; i++) begin
            ql[i].push_back((i < m) ? mat_a[i][kk] : '0);
            qu[i].push_back((i < n) ? mat_b[kk][i] : '0);
         end
      end
      d = e + k + 1 + c0 + F;
      exp_done[d] = 1;
      for (int c = e + 1; c <= d; c++) exp_busy[c] = 1;
      last_done = d;
   endtask

   task automatic set_dims(input int m, input int k, input int n, input bit acc);
      m_dim_i      = DIM_W'(m);
      k_dim_i      = DIM_W'(k);
      n_dim_i      = DIM_W'(n);
      accumulate_i = acc;
   endtask

   // Called at a negedge: pulse start for one cycle.
   task automatic op(input int m, input int k, input int n, input bit acc);
      set_dims(m, k, n, acc);
      start_i = 1'b1;
      sched(cyc + 1, m, k, n, acc);
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   task automatic bad_op(input int m, input int k, input int n);
      set_dims(m, k, n, 1'b0);
      start_i = 1'b1;
      exp_err[cyc+1] = 1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) @(negedge clk_i);
   endtask

   task automatic wait_idle();
      while (cyc <= last_done + 1) @(negedge clk_i);
   endtask

   task automatic rand_mats();
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            mat_a[i][j] = $urandom | 32'h1;
            mat_b[i][j] = $urandom | 32'h100;
         end
   endtask

   initial begin
      int e;
      for (int i = 0; i < MD; i++)
         for (int j = 0; j < MD; j++) begin
            mat_a[i][j] = (i == j) ? 32'd1 : 32'd0;
            mat_b[i][j] = 32'(4 * i + j + 1);
         end
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Full 4x4x4, clear mode, identity A.
      op(4, 4, 4, 1'b0);
      wait_idle();

      // 2x3x3 accumulate, padding lanes must stay zero.
      rand_mats();
      op(2, 3, 3, 1'b1);
      wait_idle();

      // Rejected starts.
      bad_op(2, 0, 2);
      bad_op(5, 2, 2);

      // start_i held high across two ops.
      rand_mats();
      set_dims(3, 2, 4, 1'b0);
      start_i = 1'b1;
      sched(cyc + 1, 3, 2, 4, 1'b0);
      e = last_done + 2;
      sched(e, 3, 2, 4, 1'b0);
      while (cyc < e) @(negedge clk_i);
      start_i = 1'b0;
      wait_idle();

      // Async reset while FEED is at k=2.
      rand_mats();
      e = cyc + 1;
      op(4, 4, 4, 1'b0);
      while (cyc < e + 2) @(negedge clk_i);
      @(posedge clk_i);
      #3;
      rst_i = 1'b1;
      for (int t = cyc; t < T; t++) begin
         exp_busy[t] = 0; exp_done[t] = 0; exp_err[t] = 0;
         exp_clear[t] = 0; exp_rd[t] = 0; exp_vld[t] = 0; exp_addr[t] = 0;
      end
      for (int i = 0; i < MD; i++) begin
         ql[i].delete();
         qu[i].delete();
      end
      #1;
      chk("rst_busy", busy_o, 0);
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_rd_addr", rd_addr_o, 0);
      chk("rst_clear", clear_o, 0);
      chk("rst_vld", lane0_vld_o, 0);
      chk("rst_left_any", |left_o, 0);
      chk("rst_up_any", |up_o, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      op(4, 4, 2, 1'b1);
      wait_idle();

      // 1x1x1 clear mode.
      rand_mats();
      op(1, 1, 1, 1'b0);
      wait_idle();
      repeat (4) @(negedge clk_i);

      for (int i = 0; i < MD; i++) begin
         chk("sb_left_drained", ql[i].size(), 0);
         chk("sb_up_drained", qu[i].size(), 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
